// File: rtl/scnn_pkg.sv
// Shared geometry and FSM encoding for the SCNN accumulator scatter block.
package scnn_pkg;

   localparam int NLANES = 16;
   localparam int NBANKS = 4;
   localparam int NROWS  = 8;
   localparam int CORD_W = 5;
   localparam int BANK_W = 2;
   localparam int ROW_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCATTER = 2'd1,
      ST_CLEAR   = 2'd2
   } state_e;

   function automatic logic [BANK_W-1:0] cord_bank(input logic [CORD_W-1:0] c);
      return c[1:0];
   endfunction

   function automatic logic [ROW_W-1:0] cord_row(input logic [CORD_W-1:0] c);
      return c[4:2];
   endfunction

endpackage

// File: rtl/scnn_lane_arbiter.sv
// Per-bank arbiter: grants the lowest-index requesting lane whose coordinate
// falls in this bank.
module scnn_lane_arbiter
   import scnn_pkg::*;
(
   input  logic [NLANES-1:0]             req,
   input  logic [NLANES-1:0][BANK_W-1:0] lane_bank,
   input  logic [BANK_W-1:0]             bank_id,
   output logic [NLANES-1:0]             grant,
   output logic                          grant_any
);

   logic [NLANES-1:0] match;

   always_comb begin
      match = '0;
      for (int l = 0; l < NLANES; l++) begin
         match[l] = req[l] && (lane_bank[l] == bank_id);
      end
   end

   // Two's-complement trick isolates the lowest set bit.
   assign grant     = match & (~match + NLANES'(1));
   assign grant_any = |match;

endmodule

// File: rtl/scnn_accum_scatter.sv
// Scatter-accumulate of 16-lane product groups into 32 saturating accumulators
// organised as 4 banks x 8 rows; one lane per bank retires per cycle.
module scnn_accum_scatter
   import scnn_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NLANES-1:0][DATA_W-1:0]    in_prod,
   input  logic [NLANES-1:0][CORD_W-1:0]    in_cords,
   input  logic [NLANES-1:0]                in_mask,
   input  logic                             clear,
   input  logic                             rd_en,
   input  logic [CORD_W-1:0]                rd_addr,
   output logic [ACC_W-1:0]                 rd_data,
   output logic                             busy
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_e                            state_q, state_d;
   logic [NLANES-1:0]                 pending_q, pending_d;
   logic [ROW_W-1:0]                  clr_row_q, clr_row_d;
   logic [NLANES-1:0][DATA_W-1:0]     prod_q, prod_d;
   logic [NLANES-1:0][CORD_W-1:0]     cords_q, cords_d;
   logic signed [ACC_W-1:0]           acc_q [NBANKS][NROWS];
   logic signed [ACC_W-1:0]           acc_d [NBANKS][NROWS];
   logic [ACC_W-1:0]                  rd_data_q, rd_data_d;

   logic                              handshake;
   logic                              scatter_done;
   logic [NLANES-1:0][BANK_W-1:0]     lane_bank;
   logic [NBANKS-1:0][NLANES-1:0]     grant;
   logic [NBANKS-1:0]                 grant_any;
   logic [NLANES-1:0]                 retired;
   logic signed [DATA_W-1:0]          sel_prod [NBANKS];
   logic [ROW_W-1:0]                  sel_row  [NBANKS];

   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0]  a,
      input logic signed [DATA_W-1:0] p
   );
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){p[DATA_W-1]}}, p};
      if (s[ACC_W] != s[ACC_W-1]) begin
         return s[ACC_W] ? ACC_MIN : ACC_MAX;
      end
      return s[ACC_W-1:0];
   endfunction

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d = ST_CLEAR;
            end else if (handshake && (in_mask != '0)) begin
               state_d = ST_SCATTER;
            end
         end
         ST_SCATTER: begin
            if (scatter_done) state_d = ST_IDLE;
         end
         ST_CLEAR: begin
            if (clr_row_q == ROW_W'(NROWS-1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_q == ST_IDLE) && !clear;
      busy     = (state_q != ST_IDLE);
   end

   assign handshake = in_valid && in_ready;

   always_comb begin
      for (int l = 0; l < NLANES; l++) begin
         lane_bank[l] = cord_bank(cords_q[l]);
      end
   end

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      scnn_lane_arbiter u_arb (
         .req       (pending_q),
         .lane_bank (lane_bank),
         .bank_id   (BANK_W'(b)),
         .grant     (grant[b]),
         .grant_any (grant_any[b])
      );
   end

   always_comb begin
      retired = '0;
      for (int b = 0; b < NBANKS; b++) begin
         retired     = retired | grant[b];
         sel_prod[b] = '0;
         sel_row[b]  = '0;
         for (int l = 0; l < NLANES; l++) begin
            if (grant[b][l]) begin
               sel_prod[b] = $signed(prod_q[l]);
               sel_row[b]  = cord_row(cords_q[l]);
            end
         end
      end
   end

   assign scatter_done = ((pending_q & ~retired) == '0);

   always_comb begin
      pending_d = pending_q;
      prod_d    = prod_q;
      cords_d   = cords_q;
      clr_row_d = '0;
      if (state_q == ST_IDLE && handshake) begin
         pending_d = in_mask;
         prod_d    = in_prod;
         cords_d   = in_cords;
      end else if (state_q == ST_SCATTER) begin
         pending_d = pending_q & ~retired;
      end else if (state_q == ST_CLEAR) begin
         clr_row_d = clr_row_q + ROW_W'(1);
      end
   end

   // Accumulator update: at most one write per bank per cycle.
   always_comb begin
      acc_d = acc_q;
      if (state_q == ST_SCATTER) begin
         for (int b = 0; b < NBANKS; b++) begin
            if (grant_any[b]) begin
               acc_d[b][sel_row[b]] = sat_add(acc_q[b][sel_row[b]], sel_prod[b]);
            end
         end
      end else if (state_q == ST_CLEAR) begin
         for (int b = 0; b < NBANKS; b++) begin
            acc_d[b][clr_row_q] = '0;
         end
      end
   end

   // Read returns the pre-update value of this cycle.
   assign rd_data_d = rd_en ? acc_q[cord_bank(rd_addr)][cord_row(rd_addr)] : rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         clr_row_q <= '0;
         rd_data_q <= '0;
         for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NROWS; r++) begin
               acc_q[b][r] <= '0;
            end
         end
      end else begin
         pending_q <= pending_d;
         clr_row_q <= clr_row_d;
         rd_data_q <= rd_data_d;
         acc_q     <= acc_d;
      end
   end

   always_ff @(posedge clk) begin
      prod_q  <= prod_d;
      cords_q <= cords_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_scnn_accum_scatter.sv
// Directed bench for scnn_accum_scatter: vector table plus hand sequences for
// clear, saturation and reset corner cases.
module tb_scnn_accum_scatter;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 24;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [15:0][DATA_W-1:0] in_prod;
   logic [15:0][4:0]        in_cords;
   logic [15:0]             in_mask;
   logic                    clear = 1'b0;
   logic                    rd_en = 1'b0;
   logic [4:0]              rd_addr;
   logic [ACC_W-1:0]        rd_data;
   logic                    busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int                 pat;
      logic signed [15:0] prod;
      logic [15:0]        mask;
      int                 exp_cyc;
      int                 addr;
      logic signed [23:0] exp_val;
   } vec_t;

   vec_t vt [8];

   scnn_accum_scatter #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_prod  (in_prod),
      .in_cords (in_cords),
      .in_mask  (in_mask),
      .clear    (clear),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0 identity, 1 all 5, 2 even, 3 lane&3, 4 reversed, 5 lane+16, other all 0
   function automatic logic [15:0][4:0] mk_cords(input int pat);
      logic [15:0][4:0] c;
      for (int l = 0; l < 16; l++) begin
         case (pat)
            0:       c[l] = 5'(l);
            1:       c[l] = 5'd5;
            2:       c[l] = 5'(2*l);
            3:       c[l] = 5'(l & 3);
            4:       c[l] = 5'(31 - l);
            5:       c[l] = 5'(l + 16);
            default: c[l] = 5'd0;
         endcase
      end
      return c;
   endfunction

   task automatic load_group(input int pat, input logic signed [15:0] p, input logic [15:0] m);
      in_cords = mk_cords(pat);
      for (int l = 0; l < 16; l++) in_prod[l] = p;
      in_mask = m;
   endtask

   task automatic send(input int pat, input logic signed [15:0] p, input logic [15:0] m,
                       output int cyc, output int rdy_lo);
      load_group(pat, p, m);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      rdy_lo = 0;
      while (busy && cyc < 40) begin
         cyc++;
         if (!in_ready) rdy_lo++;
         tick();
      end
   endtask

   task automatic rd(input int a, output logic signed [ACC_W-1:0] v);
      rd_en   = 1'b1;
      rd_addr = 5'(a);
      tick();
      rd_en = 1'b0;
      v = $signed(rd_data);
   endtask

   task automatic do_clear(output int cyc);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      cyc = 0;
      while (busy && cyc < 20) begin
         cyc++;
         tick();
      end
   endtask

   initial begin
      int cyc, rl, ccyc;
      logic signed [ACC_W-1:0] v;

      vt[0] = '{0,    1, 16'hFFFF,  4, 15,   1};
      vt[1] = '{1,    2, 16'hFFFF, 16,  5,  32};
      vt[2] = '{2,    3, 16'hFFFF,  8, 30,   3};
      vt[3] = '{1,   -7, 16'h0001,  1,  5,  -7};
      vt[4] = '{0,   -1, 16'h000F,  1,  3,  -1};
      vt[5] = '{3,    4, 16'hFFFF,  4,  2,  16};
      vt[6] = '{4,  100, 16'hF0F0,  2, 24, 100};
      vt[7] = '{0,    5, 16'h1111,  4, 12,   5};

      in_prod  = '0;
      in_cords = '0;
      in_mask  = '0;
      rd_addr  = '0;

      #12;
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_reset_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         do_clear(ccyc);
         send(vt[i].pat, vt[i].prod, vt[i].mask, cyc, rl);
         check($sformatf("vec%0d_cycles", i), cyc, vt[i].exp_cyc);
         rd(vt[i].addr, v);
         check($sformatf("vec%0d_acc%0d", i, vt[i].addr), v, vt[i].exp_val);
      end

      // Full identity scatter and read-back of every accumulator.
      do_clear(ccyc);
      check("clear_cycles", ccyc, 8);
      send(0, 1, 16'hFFFF, cyc, rl);
      check("ident_cycles", cyc, 4);
      for (int a = 0; a < 32; a++) begin
         rd(a, v);
         check($sformatf("ident_acc%0d", a), v, (a < 16) ? 1 : 0);
      end
      rd(3, v);
      rd_addr = 5'd20;
      tick();
      check("rd_data_hold", $signed(rd_data), 1);

      // All lanes on one coordinate serialize.
      do_clear(ccyc);
      send(1, 2, 16'hFFFF, cyc, rl);
      check("same_cord_cycles", cyc, 16);
      check("same_cord_ready_low", rl, 16);
      rd(5, v);
      check("same_cord_acc5", v, 32);

      // Empty mask is accepted without side effects.
      send(0, 9, 16'h0000, cyc, rl);
      check("mask0_busy_cycles", cyc, 0);
      check("mask0_in_ready", in_ready, 1);
      rd(5, v);
      check("mask0_acc5", v, 32);
      rd(0, v);
      check("mask0_acc0", v, 0);

      // Clear pulsed mid-scatter is ignored.
      load_group(1, 2, 16'hFFFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         clear = (cyc == 3);
         tick();
      end
      clear = 1'b0;
      check("clr_in_scatter_cycles", cyc, 16);
      rd(5, v);
      check("clr_in_scatter_acc5", v, 64);

      // Clear wins over a simultaneous group; group accepted afterwards.
      send(5, 9, 16'hFFFF, cyc, rl);
      check("upper_cycles", cyc, 4);
      load_group(0, 1, 16'hFFFF);
      in_valid = 1'b1;
      clear = 1'b1;
      #1;
      check("clr_prio_in_ready", in_ready, 0);
      tick();
      clear = 1'b0;
      cyc = 0;
      rl = 0;
      while (busy && cyc < 20) begin
         cyc++;
         if (in_ready) rl++;
         tick();
      end
      check("clr_prio_cycles", cyc, 8);
      check("clr_prio_ready_high", rl, 0);
      check("clr_prio_ready_after", in_ready, 1);
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         tick();
      end
      check("clr_prio_group_cycles", cyc, 4);
      rd(20, v);
      check("clr_prio_acc20", v, 0);
      rd(31, v);
      check("clr_prio_acc31", v, 0);
      rd(5, v);
      check("clr_prio_acc5", v, 1);

      // Positive and negative saturation.
      do_clear(ccyc);
      for (int g = 0; g < 300; g++) send(6, 16'sd32767, 16'hFFFF, cyc, rl);
      check("sat_pos_cycles", cyc, 16);
      rd(0, v);
      check("sat_pos_acc0", v, 8388607);
      do_clear(ccyc);
      for (int g = 0; g < 300; g++) send(6, -16'sd32768, 16'hFFFF, cyc, rl);
      rd(0, v);
      check("sat_neg_acc0", v, -8388608);
      rd(1, v);
      check("sat_neg_acc1", v, 0);

      // Reset asserted mid-scatter.
      rd(0, v);
      load_group(1, 2, 16'hFFFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1);
      rd(5, v);
      check("post_rst_acc5", v, 0);
      rd(0, v);
      check("post_rst_acc0", v, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
